// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results vs. buffered load returns.
// Optional WB_R0_DISCARD_EN: results targeting r0 complete but are never written.
module regfile_wb_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_da,
  input  logic [DW-1:0]            alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_da,
  input  logic [DW-1:0]            mem_data,
  output logic                     RW,
  output logic [AW-1:0]            DA,
  output logic [DW-1:0]            D_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fifo_da   [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          stall_q;
  logic          full, empty;
  logic          alu_r0, mem_r0;
  logic          wr_alu, pop, push;

`ifdef WB_R0_DISCARD_EN
  assign alu_r0 = (alu_da == '0);
  assign mem_r0 = (mem_da == '0);
`else
  assign alu_r0 = 1'b0;
  assign mem_r0 = 1'b0;
`endif

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign fifo_count = count;

  assign alu_ready = alu_valid && !full && !reset;
  assign mem_ready = !full && !stall_q && !reset;
  assign push      = mem_valid && mem_ready && !mem_r0;

  // A full FIFO outranks the ALU so loads can never deadlock the port.
  always_comb begin
    wr_alu = 1'b0;
    pop    = 1'b0;
    if (full)
      pop = 1'b1;
    else if (alu_valid && !alu_r0)
      wr_alu = 1'b1;
    else if (!empty)
      pop = 1'b1;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count)
        pend_mask[fifo_da[rd_ptr + PW'(i)]] = 1'b1;
    end
`ifdef WB_R0_DISCARD_EN
    pend_mask[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_da[wr_ptr]   <= mem_da;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      stall_q <= alu_valid && !alu_ready;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RW     <= 1'b0;
      DA     <= '0;
      D_data <= '0;
    end else if (wr_alu) begin
      RW     <= 1'b1;
      DA     <= alu_da;
      D_data <= alu_data;
    end else if (pop) begin
      RW     <= 1'b1;
      DA     <= fifo_da[rd_ptr];
      D_data <= fifo_data[rd_ptr];
    end else begin
      RW <= 1'b0;
    end
  end

endmodule
